// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO of arbitrary depth with count, thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int AF_THRESH  = 3,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] PONE_C  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   ONE_C   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH + 1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  empty_q, full_q, af_q, ae_q;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  push_ok, pop_ok;

    // Wrap at FIFO_DEPTH so non-power-of-two depths never touch unused slots
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_C) ? '0 : p + PONE_C;
    endfunction

    assign pop_ok  = pop & ~empty_q;
    assign push_ok = push & (~full_q | pop_ok);

    always_comb begin
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + ONE_C;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - ONE_C;
        end
        // A fresh error event takes priority over the clear
        ovf_d = (push & ~push_ok) | (ovf_q & ~clr_err);
        unf_d = (pop & empty_q) | (unf_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == DEPTH_C);
            af_q     <= (count_d >= AF_C);
            ae_q     <= (count_d <= AE_C);
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out = mem_q[rd_ptr_q];
`else
    logic [DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q <= '0;
        end else if (pop_ok) begin
            dout_q <= mem_q[rd_ptr_q];
        end
    end

    assign data_out = dout_q;
`endif

    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: depth-4 and depth-5 instances share stimulus
// and are checked against a queue-based reference model.
module tb_sync_fifo_flags;

    logic        clk;
    logic        reset;
    logic        push;
    logic        pop;
    logic        clr_err;
    logic [31:0] data_in;

    logic [31:0] dout_a, dout_b;
    logic        empty_a, full_a, af_a, ae_a, ovf_a, unf_a;
    logic        empty_b, full_b, af_b, ae_b, ovf_b, unf_b;
    logic [2:0]  count_a;
    logic [3:0]  count_b;
    logic [83:0] obs;

    int nvec = 0;
    int nmis = 0;

    int          depth_m [2] = '{4, 5};
    int          af_m    [2] = '{3, 4};
    int          ae_m    [2] = '{1, 1};
    logic [31:0] mq      [2][$];
    logic [31:0] mdout   [2];
    bit          movf    [2];
    bit          munf    [2];

    sync_fifo_flags u_a (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in),
        .pop(pop), .data_out(dout_a), .empty(empty_a), .full(full_a),
        .almost_full(af_a), .almost_empty(ae_a), .count(count_a),
        .overflow(ovf_a), .underflow(unf_a), .clr_err(clr_err)
    );

    sync_fifo_flags #(
        .DATA_WIDTH(32), .FIFO_DEPTH(5), .ADDR_WIDTH(3),
        .AF_THRESH(4), .AE_THRESH(1)
    ) u_b (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in),
        .pop(pop), .data_out(dout_b), .empty(empty_b), .full(full_b),
        .almost_full(af_b), .almost_empty(ae_b), .count(count_b),
        .overflow(ovf_b), .underflow(unf_b), .clr_err(clr_err)
    );

    assign obs = {1'b0, count_a, empty_a, full_a, af_a, ae_a, ovf_a, unf_a, dout_a,
                  count_b, empty_b, full_b, af_b, ae_b, ovf_b, unf_b, dout_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [83:0] exp_vec();
        logic [41:0] part [2];
        for (int k = 0; k < 2; k++) begin
            int sz;
            logic [31:0] d;
            sz = mq[k].size();
`ifdef SYNC_FIFO_FWFT_EN
            d = (sz > 0) ? mq[k][0] : 32'h0;
`else
            d = mdout[k];
`endif
            part[k] = {4'(sz), sz == 0, sz == depth_m[k], sz >= af_m[k],
                       sz <= ae_m[k], movf[k], munf[k], d};
        end
        return {part[0], part[1]};
    endfunction

    // Read data is only meaningful while non-empty in fall-through mode
    function automatic logic [83:0] mask_vec();
        logic [41:0] m [2];
        for (int k = 0; k < 2; k++) begin
            m[k] = {10'h3ff, 32'hffff_ffff};
`ifdef SYNC_FIFO_FWFT_EN
            if (mq[k].size() == 0) m[k][31:0] = 32'h0;
`endif
        end
        return {m[0], m[1]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            mdout[k] = 32'h0;
            movf[k]  = 1'b0;
            munf[k]  = 1'b0;
        end
    endtask

    task automatic step(input bit ps, input bit pp, input logic [31:0] d, input bit clr);
        push    = ps;
        pop     = pp;
        data_in = d;
        clr_err = clr;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            bit pop_ok, push_ok;
            pop_ok  = pp && mq[k].size() > 0;
            push_ok = ps && (mq[k].size() < depth_m[k] || pop_ok);
            movf[k] = (ps && !push_ok) ? 1'b1 : (clr ? 1'b0 : movf[k]);
            munf[k] = (pp && mq[k].size() == 0) ? 1'b1 : (clr ? 1'b0 : munf[k]);
            if (pop_ok) mdout[k] = mq[k].pop_front();
            if (push_ok) mq[k].push_back(d);
        end
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 32'h0, 0);
            nvec++;
            if ((obs & mask_vec()) !== (exp_vec() & mask_vec())) begin
                nmis++;
                $display("FAIL reset_idle: got %h want %h", obs & mask_vec(), exp_vec() & mask_vec());
            end
        end
        nvec++;
        if ({empty_a, full_a, ae_a, af_a, count_a, ovf_a, unf_a} !== 9'b1010_000_00) begin
            nmis++;
            $display("FAIL reset_flags: got %b want 101000000",
                     {empty_a, full_a, ae_a, af_a, count_a, ovf_a, unf_a});
        end
`ifndef SYNC_FIFO_FWFT_EN
        nvec++;
        if (dout_a !== 32'h0) begin
            nmis++;
            $display("FAIL reset_dout: got %h want 0", dout_a);
        end
`endif
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 32'hA0 + 32'(i), 0);
            nvec++;
            if ((obs & mask_vec()) !== (exp_vec() & mask_vec())) begin
                nmis++;
                $display("FAIL fill[%0d]: got %h want %h", i, obs & mask_vec(), exp_vec() & mask_vec());
            end
            if (i == 2) begin
                nvec++;
                if ({af_a, full_a, count_a} !== 5'b10_011) begin
                    nmis++;
                    $display("FAIL almost_full_at3: got %b want 10011", {af_a, full_a, count_a});
                end
            end
            if (i == 4) begin
                nvec++;
                if ({full_a, ovf_a, count_a} !== 5'b11_100) begin
                    nmis++;
                    $display("FAIL overflow_5th: got %b want 11100", {full_a, ovf_a, count_a});
                end
            end
        end
    endtask

    task automatic test_drain_underflow();
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 32'h0, 0);
            nvec++;
            if ((obs & mask_vec()) !== (exp_vec() & mask_vec())) begin
                nmis++;
                $display("FAIL drain[%0d]: got %h want %h", i, obs & mask_vec(), exp_vec() & mask_vec());
            end
`ifndef SYNC_FIFO_FWFT_EN
            if (i < 4) begin
                nvec++;
                if (dout_a !== 32'hA0 + 32'(i)) begin
                    nmis++;
                    $display("FAIL drain_data[%0d]: got %h want %h", i, dout_a, 32'hA0 + 32'(i));
                end
            end
`endif
            if (i == 4) begin
                nvec++;
                if ({empty_a, unf_a} !== 2'b11) begin
                    nmis++;
                    $display("FAIL underflow_5th: got %b want 11", {empty_a, unf_a});
                end
            end
        end
    endtask

    task automatic test_clr_err();
        step(0, 0, 32'h0, 1);
        nvec++;
        if ({ovf_a, unf_a, ovf_b, unf_b} !== 4'b0000) begin
            nmis++;
            $display("FAIL clr_err: got %b want 0000", {ovf_a, unf_a, ovf_b, unf_b});
        end
        for (int i = 0; i < 4; i++) step(1, 0, 32'hC0 + 32'(i), 0);
        step(1, 0, 32'hDEAD, 1);
        nvec++;
        if ((obs & mask_vec()) !== (exp_vec() & mask_vec()) || ovf_a !== 1'b1) begin
            nmis++;
            $display("FAIL clr_vs_overflow: got %h ovf=%b want %h ovf=1",
                     obs & mask_vec(), ovf_a, exp_vec() & mask_vec());
        end
        step(0, 0, 32'h0, 1);
    endtask

    task automatic test_full_pushpop();
        step(1, 1, 32'hBEEF, 0);
        nvec++;
        if ({count_a, full_a, ovf_a} !== 5'b100_10) begin
            nmis++;
            $display("FAIL full_pushpop: got %b want 10010", {count_a, full_a, ovf_a});
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 32'h0, 0);
            nvec++;
            if ((obs & mask_vec()) !== (exp_vec() & mask_vec())) begin
                nmis++;
                $display("FAIL full_pp_drain[%0d]: got %h want %h", i, obs & mask_vec(), exp_vec() & mask_vec());
            end
        end
`ifndef SYNC_FIFO_FWFT_EN
        nvec++;
        if (dout_a !== 32'hBEEF) begin
            nmis++;
            $display("FAIL beef_readback: got %h want 0000beef", dout_a);
        end
`endif
    endtask

    task automatic test_empty_pushpop();
        while (mq[1].size() > 0) step(0, 1, 32'h0, 0);
        step(0, 0, 32'h0, 1);
        step(1, 1, 32'h1234, 0);
        nvec++;
        if ({count_a, unf_a, empty_a} !== 5'b001_10) begin
            nmis++;
            $display("FAIL empty_pushpop: got %b want 00110", {count_a, unf_a, empty_a});
        end
        nvec++;
        if ((obs & mask_vec()) !== (exp_vec() & mask_vec())) begin
            nmis++;
            $display("FAIL empty_pp_state: got %h want %h", obs & mask_vec(), exp_vec() & mask_vec());
        end
    endtask

`ifdef SYNC_FIFO_FWFT_EN
    task automatic test_fwft();
        do_reset();
        step(1, 0, 32'h55, 0);
        step(0, 0, 32'h0, 0);
        nvec++;
        if (dout_a !== 32'h55 || dout_b !== 32'h55) begin
            nmis++;
            $display("FAIL fwft_55: got %h/%h want 55", dout_a, dout_b);
        end
    endtask
`endif

    task automatic test_random();
        bit ps, pp, clr;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            ps  = ($urandom_range(0, 99) < ((i / 200) % 2 ? 70 : 35));
            pp  = ($urandom_range(0, 99) < ((i / 200) % 2 ? 35 : 70));
            clr = ($urandom_range(0, 99) < 5);
            step(ps, pp, $urandom, clr);
            nvec++;
            if ((obs & mask_vec()) !== (exp_vec() & mask_vec())) begin
                nmis++;
                $display("FAIL random[%0d]: got %h want %h", i, obs & mask_vec(), exp_vec() & mask_vec());
            end
            nvec++;
            if (u_b.wr_ptr_q > 3'd4 || u_b.rd_ptr_q > 3'd4) begin
                nmis++;
                $display("FAIL ptr_range[%0d]: got wr=%0d rd=%0d want <=4",
                         i, u_b.wr_ptr_q, u_b.rd_ptr_q);
            end
        end
    endtask

    initial begin
        reset   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
        data_in = 32'h0;
        model_reset();
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_clr_err();
        test_full_pushpop();
        test_empty_pushpop();
`ifdef SYNC_FIFO_FWFT_EN
        test_fwft();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised successor to the team's basic synchronous FIFO. Single-clock buffer of any depth, not only powers of two. Adds programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags with a clear input. Sits between producer and consumer blocks in the same clock domain, as a drop-in upgrade to the existing push/pop FIFO.

Parameters:
DATA_WIDTH, 32, width of each stored word in bits (>=1)
FIFO_DEPTH, 4, number of entries; any integer >=2
ADDR_WIDTH, 2, pointer width; must satisfy 2**ADDR_WIDTH >= FIFO_DEPTH
AF_THRESH, 3, almost_full asserts when count >= AF_THRESH (1..FIFO_DEPTH)
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH (0..FIFO_DEPTH-1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
push  input  1  write request
data_in  input  DATA_WIDTH  write data, sampled when a push is accepted
pop  input  1  read request
data_out  output  DATA_WIDTH  read data
empty  output  1  count == 0
full  output  1  count == FIFO_DEPTH
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH
overflow  output  1  sticky; push attempted while full and not accepted
underflow  output  1  sticky; pop attempted while empty
clr_err  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (reset=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, data_out=0, overflow=0, underflow=0. Memory contents are not reset. Reset mid-operation discards all stored data. Release is sampled at the next rising edge.
- Accept rules, evaluated on registered state:
  - push_ok = push & (!full | pop_ok)
  - pop_ok = pop & !empty
  - Full with push and pop together: both are accepted and count is unchanged.
  - Empty with push and pop together: only the push is accepted, and underflow is set.
- Pointers advance by 1 on acceptance and wrap from FIFO_DEPTH-1 to 0, not at 2**ADDR_WIDTH.
- count_next = count + push_ok - pop_ok.
- All flags are registered and derived from count_next, so they are valid in the same cycle as count.
- Non-FWFT read: on pop_ok, data_out <= mem[rd_ptr] (1-cycle latency). data_out holds its value otherwise.
- Error flags:
  - overflow <= 1 on push & !push_ok.
  - underflow <= 1 on pop & empty.
  - clr_err=1 clears both flags. A new error event in the same cycle wins over the clear (flag stays 1).
- Write-through: data pushed into an empty FIFO is poppable on the following cycle. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle, sustained.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out always presents mem[rd_ptr] whenever empty=0, with no pop required.
  - pop_ok acknowledges that word and advances rd_ptr; the next word appears on data_out in the following cycle.
  - data_out is don't-care while empty=1.
- Undefined: standard 1-cycle registered read, as described under Behaviour.

Test Plan:
- Reset, then idle 3 cycles -> empty=1, full=0, almost_empty=1, count=0, data_out=0, overflow=underflow=0.
- Push 0xA0..0xA9 on 10 consecutive cycles (DEPTH=4) -> count reaches 4 after 4 pushes; almost_full at count 3; full=1; overflow=1 after the 5th push; words 0xA4..0xA9 are dropped.
- Pop 10 consecutive cycles -> data_out returns 0xA0, 0xA1, 0xA2, 0xA3 each 1 cycle after its pop; empty=1 after the 4th pop; underflow=1 on the 5th pop.
- FIFO_DEPTH=5, ADDR_WIDTH=3: push/pop 12 words interleaved -> data_out matches data_in in order; pointers wrap at 4->0 and never reach 5..7.
- Full with push and pop together (data_in=0xBEEF) -> count stays 4, overflow stays 0, 0xBEEF is read back 4 pops later. Empty with push and pop together -> count=1, underflow=1.
- clr_err pulse -> both sticky flags drop next cycle. clr_err together with a new overflow -> overflow stays 1. With SYNC_FIFO_FWFT_EN: push 0x55 -> data_out=0x55 the next cycle with no pop issued.
